// File: rtl/pow.sv
// Iterative unsigned power unit: result = low 32 bits of base**expo, with sticky
// overflow flags, computed by repeated multiplication (one multiply per cycle).
module pow (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base,
  input  logic [15:0] expo,
  output logic        ready,
  output logic [31:0] result,
  output logic        Cflag,
  output logic        Oflag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] b_q, b_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        carry_q, carry_d;
  logic [31:0] result_q, result_d;
  logic        cflag_q, cflag_d;
  logic        oflag_q, oflag_d;
  logic        ready_q, ready_d;
  logic [47:0] prod;

  // acc only ever holds 32 bits, so the full 32x16 product fits in 48 bits.
  assign prod = {16'd0, acc_q} * {32'd0, b_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      b_q      <= 16'd0;
      cnt_q    <= 16'd0;
      acc_q    <= 32'd0;
      carry_q  <= 1'b0;
      result_q <= 32'd0;
      cflag_q  <= 1'b0;
      oflag_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cflag_q  <= cflag_d;
      oflag_q  <= oflag_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    result_d = result_q;
    cflag_d  = cflag_q;
    oflag_d  = oflag_q;
    ready_d  = ready_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = base;
          cnt_d   = expo;
          acc_d   = 32'd1;
          carry_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != 16'd0) begin
          acc_d   = prod[31:0];
          cnt_d   = cnt_q - 16'd1;
          // Sticky: once the true value passes 2**32 it can never come back
          carry_d = carry_q | (prod[47:32] != 16'd0);
        end else begin
          result_d = acc_q;
          cflag_d  = carry_q;
          oflag_d  = carry_q | acc_q[31];
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ready  = ready_q;
  assign result = result_q;
  assign Cflag  = cflag_q;
  assign Oflag  = oflag_q;

endmodule

// File: tb/tb_pow.sv
// Scoreboard bench for pow: driver pushes model results, monitor checks each
// ready rise for value, flags and latency, and checks outputs hold in between.
module tb_pow;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base;
  logic [15:0] expo;
  logic        ready;
  logic [31:0] result;
  logic        Cflag;
  logic        Oflag;

  pow dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (base),
    .expo   (expo),
    .ready  (ready),
    .result (result),
    .Cflag  (Cflag),
    .Oflag  (Oflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
    int          lat;
    int          cap;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic [31:0] held_r = 32'd0;
  logic        held_c = 1'b0;
  logic        held_o = 1'b0;
  logic        prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain repeated multiplication; the true magnitude is tracked
  // with saturation at 2**33 so the flag thresholds are exact.
  function automatic exp_t model(int unsigned b, int unsigned e, int cap);
    exp_t x;
    longint unsigned low, sat;
    localparam longint unsigned SAT = 64'd1 << 33;
    low = 1;
    sat = 1;
    for (int unsigned i = 0; i < e; i++) begin
      low = (low * b) & 64'hFFFF_FFFF;
      sat = sat * b;
      if (sat > SAT) sat = SAT;
    end
    x.r   = low[31:0];
    x.c   = (sat >= (64'd1 << 32));
    x.o   = (sat >= (64'd1 << 31));
    x.lat = int'(e) + 1;
    x.cap = cap;
    return x;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        prev_ready = 1'b0;
      end else if (ready && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 64'(ready), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result",  64'(result), 64'(e.r));
          check("Cflag",   64'(Cflag),  64'(e.c));
          check("Oflag",   64'(Oflag),  64'(e.o));
          check("latency", 64'(cyc - e.cap), 64'(e.lat));
          held_r = e.r;
          held_c = e.c;
          held_o = e.o;
        end
        done_cnt++;
        prev_ready = ready;
      end else begin
        check("held_result", 64'(result), 64'(held_r));
        check("held_flags",  64'({Cflag, Oflag}), 64'({held_c, held_o}));
        prev_ready = ready;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    start = 1'b0;
    sb.delete();
    held_r = 32'd0;
    held_c = 1'b0;
    held_o = 1'b0;
    #1;
    check("rst_ready",  64'(ready), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags",  64'({Cflag, Oflag}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] b, input logic [15:0] e,
                        input int hold_extra, input bit perturb);
    int d0;
    bit got;
    @(negedge clk);
    base  = b;
    expo  = e;
    start = 1'b1;
    sb.push_back(model(b, e, cyc + 1));
    d0  = done_cnt;
    got = 1'b0;
    for (int k = 0; k < int'(e) + 20; k++) begin
      @(negedge clk);
      if (perturb) begin
        base = 16'($urandom);
        expo = 16'($urandom);
      end
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("ready_timeout", 64'd0, 64'd1);
      do_reset();
      return;
    end
    // start still high: must stay in DONE, never relaunch
    for (int k = 0; k < hold_extra; k++) begin
      @(negedge clk);
      check("ready_hold", 64'(ready), 64'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'(ready), 64'd0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    base  = 16'd0;
    expo  = 16'd0;
    #12;
    check("por_ready",  64'(ready), 64'd0);
    check("por_result", 64'(result), 64'd0);
    check("por_flags",  64'({Cflag, Oflag}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(16'd5, 16'd5, 3, 1'b0);
    repeat (10) @(negedge clk);
    run_op(16'd21, 16'd3, 0, 1'b1);
    run_op(16'd2, 16'd31, 1, 1'b0);
    run_op(16'd65535, 16'd2, 0, 1'b0);
    run_op(16'd2, 16'd32, 0, 1'b1);
    run_op(16'd3, 16'd40, 0, 1'b0);
    run_op(16'd0, 16'd0, 2, 1'b0);
    run_op(16'd0, 16'd5, 0, 1'b0);
    run_op(16'd7, 16'd0, 0, 1'b0);
    run_op(16'd1, 16'd37, 0, 1'b0);
    run_op(16'd65535, 16'd3, 0, 1'b0);

    // Abort mid-calculation, then re-run
    @(negedge clk);
    base  = 16'd5;
    expo  = 16'd5;
    start = 1'b1;
    repeat (4) @(posedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_no_ready", 64'(ready), 64'd0);
    run_op(16'd5, 16'd5, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] b;
      logic [15:0] e;
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 3));
        1:       b = 16'($urandom_range(4, 300));
        default: b = 16'($urandom);
      endcase
      e = 16'($urandom_range(0, 40));
      run_op(b, e, int'($urandom_range(0, 2)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pow.md
POW -- requirements
Module: pow

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; level, sampled on clk.
REQ-005 base  input  16  unsigned base operand.
REQ-006 expo  input  16  unsigned exponent operand.
REQ-007 ready  output  1  registered; high only in DONE state.
REQ-008 result  output  32  registered; low 32 bits of base**expo.
REQ-009 Cflag  output  1  registered; true base**expo >= 2**32.
REQ-010 Oflag  output  1  registered; true base**expo >= 2**31.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 IDLE, start=1 at an edge: latch base into b_reg, expo into cnt, acc<=1, carry<=0, go CALC; IDLE, start=0: stay.
REQ-013 CALC, cnt!=0: acc<=low 32 bits of acc*b_reg (48-bit product), cnt<=cnt-1, carry<=carry OR (product[47:32]!=0); stay CALC.
REQ-014 CALC, cnt==0: result<=acc, Cflag<=carry, Oflag<=carry OR acc[31], go DONE.
REQ-015 DONE: ready=1; stay while start=1; start=0 at an edge -> IDLE.
REQ-016 ready SHALL be 0 in IDLE and CALC.
REQ-017 Latency: ready rises exactly expo+1 clock edges after the edge that sampled start in IDLE (expo multiplications plus one completion cycle).
REQ-018 result, Cflag, Oflag SHALL change only on the CALC->DONE edge and hold through DONE, IDLE and the next CALC.
REQ-019 base, expo and start changes during CALC SHALL be ignored; operands are those latched in IDLE.
REQ-020 0**0 SHALL yield result=1, flags 0; any base with expo=0 SHALL yield 1.
REQ-021 0**n (n>0) SHALL yield 0, flags 0; 1**n SHALL yield 1, flags 0.
REQ-022 On wrap, result SHALL be the true value mod 2**32; carry is sticky once set.
REQ-023 start held high continuously SHALL NOT start a new operation until DONE->IDLE via start=0 has occurred.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, ready=0, result=0, Cflag=0, Oflag=0, acc=0, cnt=0, b_reg=0, carry=0, independent of clk.
REQ-025 rst=0 during CALC SHALL abort the operation; no partial result appears; after release the block waits in IDLE for start.
REQ-026 Internal state leaves reset on the first rising edge after rst returns high.

Verification
REQ-027 Reset then base=5, expo=5, start=1 held until ready -> ready rises 6 edges after capture; result=3125 (0x00000C35), Cflag=0, Oflag=0.
REQ-028 start=0, wait 10 cycles, base=21, expo=3, start=1 -> ready after 4 edges; result=9261, Cflag=0, Oflag=0; earlier result held until then.
REQ-029 base=2, expo=31 -> result=0x80000000, Cflag=0, Oflag=1; base=65535, expo=2 -> 0xFFFE0001, Cflag=0, Oflag=1.
REQ-030 base=2, expo=32 -> result=0, Cflag=1, Oflag=1; base=3, expo=40 -> result=3**40 mod 2**32, Cflag=1, Oflag=1.
REQ-031 base=0/expo=0 -> 1 after 1 edge; base=0/expo=5 -> 0; base=7/expo=0 -> 1; all flags 0.
REQ-032 rst=0 mid-CALC (base=5, expo=5, after 3 edges) -> ready, result, flags 0 immediately; re-run gives 3125.
